ps2_receiver: RTL and testbench
===============================

# ps2_receiver

Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` pins, validates them, and strips the `E0` and `F0` prefix bytes. It delivers one 8-bit scancode per key event, qualified by a one-cycle strobe. It sits directly upstream of the scancode-to-character decoder, whose `scancode`/`flag` inputs it drives: `flag` fires for make codes only, so that decoder never sees prefix bytes or release codes.

## Interface
- `TIMEOUT_CYCLES`, default 50000: clk cycles without a ps2_clk falling edge before a partial frame is aborted (1 ms at 50 MHz).
- `clk`, input, 1: system clock, 50 MHz nominal; all logic on its rising edge.
- `reset`, input, 1: synchronous, active-high; overrides every other event.
- `ps2_clk`, input, 1: raw keyboard clock, asynchronous to `clk`.
- `ps2_data`, input, 1: raw keyboard data, asynchronous to `clk`.
- `scancode`, output, 8: last delivered code; holds until the next delivery.
- `flag`, output, 1: one-cycle pulse, make code valid on `scancode`.
- `release`, output, 1: one-cycle pulse, break code (preceded by `F0`) valid on `scancode`.
- `ext`, output, 1: level; 1 if the code currently on `scancode` was preceded by `E0`.
- `frame_err`, output, 1: one-cycle pulse on start, parity, stop or timeout failure.

## Operation
- Both pins pass through a 2-flop synchronizer. A falling edge of synchronized `ps2_clk` is the sample event, and synchronized `ps2_data` is sampled at that event.
- Frame format: 11 bits, LSB-first data.
  - bit0: start = 0
  - bits1–8: data
  - bit9: odd parity (data plus parity bit contain an odd number of ones)
  - bit10: stop = 1
- State `IDLE`:
  - On a sample event with data 0: go to `SHIFT`, bit count = 1.
  - On a sample event with data 1: stay in `IDLE`, no error. This covers a glitch or a lost start bit.
- State `SHIFT`:
  - Shift one bit per sample event.
  - After bit10 is taken, go to `CHECK`.
  - Timeout counter clears on each sample event and increments otherwise.
  - When the counter reaches `TIMEOUT_CYCLES`: pulse `frame_err`, clear prefixes, go to `IDLE`.
- State `CHECK` lasts one cycle, then returns to `IDLE`. It evaluates the frame as follows:
  - Parity or stop failure: pulse `frame_err`, clear prefixes, outputs unchanged.
  - Byte `E0`: set `pend_ext`; no strobe.
  - Byte `F0`: set `pend_break`; no strobe.
  - Any other byte:
    - Load `scancode` and set `ext` = `pend_ext`.
    - Pulse `release` if `pend_break`, else pulse `flag`.
    - Clear both prefixes.
- `flag` and `release` are never high in the same cycle.
- Repeated `E0`/`F0` bytes are idempotent.
- Reset values: state `IDLE`, `scancode` = 0x00, `flag` = 0, `release` = 0, `ext` = 0, `frame_err` = 0, prefixes cleared, counters 0, synchronizer flops 1 (bus idle).

## Timing
- Latency is fixed: `flag`/`release` go high exactly 4 clk edges after the edge at which the first synchronizer flop captures the stop-bit falling edge of `ps2_clk`.
- `scancode` and `ext` change on the same edge as the strobe and are stable from then until the next strobe.
- `frame_err` for a parity or stop failure has the same 4-edge latency.
- `frame_err` for a timeout asserts on the cycle after the counter reaches `TIMEOUT_CYCLES`.
- A sample event and a timeout in the same cycle: the sample event wins and the counter clears.
- Reset asserted mid-frame: partial frame discarded, no strobe, no `frame_err`.
- PS/2 bit period (≥ 60 µs) greatly exceeds the `CHECK` duration, so a frame is never lost while in `CHECK`. The design is nevertheless correct if a sample event arrives during `CHECK`: it is handled as in `IDLE` on the following cycle.

## Structure
- Package `ps2_pkg` holds:
  - `PS2_EXT_PREFIX` = 8'hE0 and `PS2_BREAK_PREFIX` = 8'hF0
  - `PS2_FRAME_BITS` = 11
  - State enum `{IDLE, SHIFT, CHECK}`
- Sub-module `ps2_sync_edge`: 2-flop synchronizers for both pins, a previous-value register, and a one-cycle `fall` pulse with aligned `data_s`.
- Top contains the FSM, the 11-bit shift register, the bit counter, the timeout counter of width $clog2(`TIMEOUT_CYCLES`+1), and the prefix flags.

## Test plan
- Frame for 0x2B (parity bit 1, stop 1) → one `flag` pulse, `scancode` = 0x2B, `ext` = 0, `release` = 0, at 4-edge latency.
- Frames `F0` then `2B` → no `flag`; one `release` pulse with `scancode` = 0x2B; the next `15` frame gives `flag` with `scancode` = 0x15.
- Frames `E0` then `75` → `flag` pulse, `scancode` = 0x75, `ext` = 1; the following `1C` gives `ext` = 0.
- Frame `15` with parity bit inverted → `frame_err` pulse, no `flag`, `scancode` keeps its previous value. Repeat with stop bit 0 → `frame_err`.
- Five bits, then `TIMEOUT_CYCLES`+2 idle cycles → exactly one `frame_err`; a subsequent clean `33` frame gives `flag` with `scancode` = 0x33.
- `reset` asserted at bit 6 of a `22` frame → no strobe and no `frame_err`; all outputs at reset values; the next clean `22` frame is received normally.

Source files
------------

// File: rtl/ps2_receiver_pkg.sv
// Shared constants, state encoding and frame-check helper for the PS/2 receiver.
package ps2_pkg;

  localparam int         PS2_FRAME_BITS   = 11;
  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } ps2_state_e;

  // Frame layout (LSB first): [0] start, [8:1] data, [9] odd parity, [10] stop.
  // A frame is good when start is 0, stop is 1 and data plus parity hold an
  // odd number of ones.
  function automatic logic ps2_frame_ok(input logic [PS2_FRAME_BITS-1:0] frame);
    return (frame[0] == 1'b0) && (^frame[9:1] == 1'b1) && (frame[10] == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_receiver_if.sv
// Scancode delivery bus between the PS/2 receiver and the scancode decoder.
interface ps2_receiver_if;

  logic [7:0] scancode;      // last delivered code, held until next delivery
  logic       flag;          // one-cycle pulse: make code on scancode
  logic       release_pulse; // one-cycle pulse: break code on scancode
  logic       ext;           // code on scancode was preceded by E0
  logic       frame_err;     // one-cycle pulse: start/parity/stop/timeout failure

  modport master (
    output scancode,
    output flag,
    output release_pulse,
    output ext,
    output frame_err
  );

  modport slave (
    input scancode,
    input flag,
    input release_pulse,
    input ext,
    input frame_err
  );

endinterface

// File: rtl/ps2_receiver_sync_edge.sv
// Two-flop synchronizers for the raw PS/2 pins plus a registered falling-edge
// detector on the keyboard clock. fall_o is a one-cycle pulse and data_s_o is
// the synchronized data bit registered alongside it.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic fall_o,
  output logic data_s_o
);

  logic clk_meta_q;
  logic clk_sync_q;
  logic clk_prev_q;
  logic data_meta_q;
  logic data_sync_q;
  logic fall_q;
  logic data_q;

  // Synchronize both pins, remember previous clock level, register edge + data.
  // Flops reset to 1 so an idle bus never produces a spurious edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      fall_q      <= 1'b0;
      data_q      <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_i;
      data_sync_q <= data_meta_q;
      fall_q      <= clk_prev_q & ~clk_sync_q;
      data_q      <= data_sync_q;
    end
  end

  assign fall_o   = fall_q;
  assign data_s_o = data_q;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard frame receiver. Collects 11-bit frames, validates start,
// parity and stop, folds E0/F0 prefix bytes into the ext/release qualifiers
// and delivers one scancode per key event.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_receiver_if.master kb
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int             BW       = $clog2(PS2_FRAME_BITS);
  localparam logic [TW-1:0]  TO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [BW-1:0]  LAST_BIT = BW'(PS2_FRAME_BITS - 1);

  logic fall;
  logic data_s;

  ps2_sync_edge u_sync (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .fall_o     (fall),
    .data_s_o   (data_s)
  );

  ps2_state_e                state_q;
  logic [PS2_FRAME_BITS-1:0] shift_q;
  logic [BW-1:0]             bit_cnt_q;
  logic [TW-1:0]             to_cnt_q;
  logic                      pend_ext_q;
  logic                      pend_brk_q;
  logic                      evt_pend_q;   // sample event that landed during CHECK
  logic                      evt_data_q;
  logic [7:0]                scancode_q;
  logic                      flag_q;
  logic                      rel_q;
  logic                      ext_q;
  logic                      err_q;

  logic                      sample_d;
  logic                      sample_bit_d;
  logic [7:0]                byte_d;

  // Merge a live sample event with one deferred from the CHECK cycle.
  always_comb begin
    sample_d     = fall | evt_pend_q;
    sample_bit_d = evt_pend_q ? evt_data_q : data_s;
    byte_d       = shift_q[8:1];
  end

  // Receiver FSM: frame assembly, timeout abort, frame evaluation and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      to_cnt_q   <= '0;
      pend_ext_q <= 1'b0;
      pend_brk_q <= 1'b0;
      evt_pend_q <= 1'b0;
      evt_data_q <= 1'b1;
      scancode_q <= 8'h00;
      flag_q     <= 1'b0;
      rel_q      <= 1'b0;
      ext_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      flag_q     <= 1'b0;
      rel_q      <= 1'b0;
      err_q      <= 1'b0;
      evt_pend_q <= 1'b0;

      case (state_q)
        IDLE: begin
          to_cnt_q <= '0;
          // A high bit here is a glitch or lost start bit: ignore quietly.
          if (sample_d && !sample_bit_d) begin
            shift_q   <= {sample_bit_d, shift_q[PS2_FRAME_BITS-1:1]};
            bit_cnt_q <= BW'(1);
            state_q   <= SHIFT;
          end
        end

        SHIFT: begin
          // A sample event beats a simultaneous timeout.
          if (fall) begin
            shift_q  <= {data_s, shift_q[PS2_FRAME_BITS-1:1]};
            to_cnt_q <= '0;
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= CHECK;
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end else if (to_cnt_q == TO_LIMIT) begin
            err_q      <= 1'b1;
            pend_ext_q <= 1'b0;
            pend_brk_q <= 1'b0;
            to_cnt_q   <= '0;
            state_q    <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end

        CHECK: begin
          state_q <= IDLE;
          if (fall) begin
            evt_pend_q <= 1'b1;
            evt_data_q <= data_s;
          end
          if (!ps2_frame_ok(shift_q)) begin
            err_q      <= 1'b1;
            pend_ext_q <= 1'b0;
            pend_brk_q <= 1'b0;
          end else if (byte_d == PS2_EXT_PREFIX) begin
            pend_ext_q <= 1'b1;
          end else if (byte_d == PS2_BREAK_PREFIX) begin
            pend_brk_q <= 1'b1;
          end else begin
            scancode_q <= byte_d;
            ext_q      <= pend_ext_q;
            rel_q      <= pend_brk_q;
            flag_q     <= !pend_brk_q;
            pend_ext_q <= 1'b0;
            pend_brk_q <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign kb.scancode      = scancode_q;
  assign kb.flag          = flag_q;
  assign kb.release_pulse = rel_q;
  assign kb.ext           = ext_q;
  assign kb.frame_err     = err_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: clean frames, prefix handling, parity/stop
// errors, timeout abort and mid-frame reset.
module tb_ps2_receiver;

  localparam int TO   = 200;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic reset;
  logic ps2_clk;
  logic ps2_data;

  ps2_receiver_if bus ();

  ps2_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kb       (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Running pulse totals, sampled 1 ns after each rising edge.
  int tot_flag = 0;
  int tot_rel  = 0;
  int tot_ferr = 0;

  always @(posedge clk) begin
    #1;
    if (bus.flag)          tot_flag = tot_flag + 1;
    if (bus.release_pulse) tot_rel  = tot_rel + 1;
    if (bus.frame_err)     tot_ferr = tot_ferr + 1;
  end

  logic [2:0] s_pre, s_at, s_post;
  int b_flag, b_rel, b_ferr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] snap();
    return {bus.flag, bus.release_pulse, bus.frame_err};
  endfunction

  function automatic logic [10:0] mk(input logic [7:0] d, input logic pflip, input logic stop);
    return {stop, (~^d) ^ pflip, d, 1'b0};
  endfunction

  task automatic mark();
    b_flag = tot_flag;
    b_rel  = tot_rel;
    b_ferr = tot_ferr;
  endtask

  // Send the first nbits of frame f. Around the final falling edge, capture
  // {flag,release,frame_err} one cycle before, at, and after the 4-edge point.
  task automatic send(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == nbits - 1) begin
        repeat (4) @(posedge clk);
        @(negedge clk); s_pre  = snap();
        @(posedge clk);
        @(negedge clk); s_at   = snap();
        @(posedge clk);
        @(negedge clk); s_post = snap();
        repeat (HALF - 6) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] d, input logic pflip, input logic stop,
                       input logic [2:0] exp_strobe);
    send(mk(d, pflip, stop), 11);
    check($sformatf("pre_%02h", d),  s_pre,  3'b000);
    check($sformatf("at_%02h", d),   s_at,   exp_strobe);
    check($sformatf("post_%02h", d), s_post, 3'b000);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_sc",   bus.scancode,      8'h00);
    check("rst_flag", bus.flag,          1'b0);
    check("rst_rel",  bus.release_pulse, 1'b0);
    check("rst_ext",  bus.ext,           1'b0);
    check("rst_err",  bus.frame_err,     1'b0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Plain make code.
    mark();
    frame(8'h2B, 1'b0, 1'b1, 3'b100);
    check("mk_sc",   bus.scancode, 8'h2B);
    check("mk_ext",  bus.ext,      1'b0);
    check("mk_nflg", tot_flag - b_flag, 1);
    check("mk_nrel", tot_rel - b_rel,   0);

    // Break sequence F0 2B, then a make 15.
    mark();
    frame(8'hF0, 1'b0, 1'b1, 3'b000);
    frame(8'h2B, 1'b0, 1'b1, 3'b010);
    check("brk_sc",   bus.scancode, 8'h2B);
    check("brk_nflg", tot_flag - b_flag, 0);
    check("brk_nrel", tot_rel - b_rel,   1);
    frame(8'h15, 1'b0, 1'b1, 3'b100);
    check("mk15_sc", bus.scancode, 8'h15);

    // Extended sequence E0 75, then 1C clears ext.
    frame(8'hE0, 1'b0, 1'b1, 3'b000);
    check("e0_sc_hold", bus.scancode, 8'h15);
    frame(8'h75, 1'b0, 1'b1, 3'b100);
    check("ext_sc",  bus.scancode, 8'h75);
    check("ext_ext", bus.ext,      1'b1);
    frame(8'h1C, 1'b0, 1'b1, 3'b100);
    check("1c_sc",  bus.scancode, 8'h1C);
    check("1c_ext", bus.ext,      1'b0);

    // Parity and stop errors leave outputs alone.
    mark();
    frame(8'h15, 1'b1, 1'b1, 3'b001);
    check("par_sc", bus.scancode, 8'h1C);
    frame(8'h15, 1'b0, 1'b0, 3'b001);
    check("stp_sc",   bus.scancode, 8'h1C);
    check("err_nflg", tot_flag - b_flag, 0);
    check("err_nerr", tot_ferr - b_ferr, 2);

    // An error clears a pending E0 prefix.
    frame(8'hE0, 1'b0, 1'b1, 3'b000);
    frame(8'h15, 1'b1, 1'b1, 3'b001);
    frame(8'h1C, 1'b0, 1'b1, 3'b100);
    check("clr_ext", bus.ext, 1'b0);

    // Timeout after five bits, then recovery.
    mark();
    send(mk(8'h33, 1'b0, 1'b1), 5);
    repeat (TO + 40) @(negedge clk);
    check("to_nerr", tot_ferr - b_ferr, 1);
    check("to_nflg", tot_flag - b_flag, 0);
    frame(8'h33, 1'b0, 1'b1, 3'b100);
    check("to_sc", bus.scancode, 8'h33);

    // Reset in the middle of a 22 frame.
    mark();
    send(mk(8'h22, 1'b0, 1'b1), 6);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (TO + 40) @(negedge clk);
    check("mr_nflg", tot_flag - b_flag, 0);
    check("mr_nrel", tot_rel - b_rel,   0);
    check("mr_nerr", tot_ferr - b_ferr, 0);
    check("mr_sc",   bus.scancode, 8'h00);
    check("mr_ext",  bus.ext,      1'b0);
    frame(8'h22, 1'b0, 1'b1, 3'b100);
    check("mr22_sc", bus.scancode, 8'h22);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
